// File: rtl/pcpu_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pcpu_arb_pkg : shared types and constants for the IF/MEM RAM arbiter
// Revision     : 1.0 - initial release
// ---------------------------------------------------------------------------
package pcpu_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic [0:0] {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_e;

  localparam int unsigned RAM_DW = 32;
  localparam logic [3:0]  BE_ALL = 4'hF;

endpackage
`default_nettype wire

// File: rtl/pcpu_arb_fair.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pcpu_arb_fair : counts MEM wins while IF waits and forces IF through
// Revision      : 1.0 - initial release
// ---------------------------------------------------------------------------
module pcpu_arb_fair #(
  parameter int unsigned MAX_STREAK = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic mem_gnt,
  input  logic if_gnt,
  output logic force_if
);

  localparam int unsigned SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;

  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (mem_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign force_if = if_req && (streak_q == STREAK_MAX);

endmodule
`default_nettype wire

// File: rtl/pcpu_mem_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pcpu_mem_arb : single-port RAM arbiter between CPU fetch and data ports.
//                Optional counters enabled by PCPU_ARB_STATS_EN.
// Revision     : 1.0 - initial release
// ---------------------------------------------------------------------------
module pcpu_mem_arb
  import pcpu_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [RAM_DW-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_be,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [RAM_DW-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [RAM_DW-1:0] mem_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [RAM_DW-1:0] ram_wdata,
  input  logic [RAM_DW-1:0] ram_rdata,
  output logic              stall_if,
  output logic              stall_mem
`ifdef PCPU_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       starve_cnt
`endif
);

  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

  arb_state_e       state_q, state_d;
  arb_owner_e       owner_q, owner_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;

  logic resp;
  logic window;
  logic take_mem;
  logic force_if;

  // The response cycle doubles as an arbitration window so reads can pipeline.
  assign resp     = (state_q == ST_WAIT) && (lat_cnt_q == '0);
  assign window   = !rst && ((state_q == ST_IDLE) || resp);
  assign take_mem = mem_req && !force_if;
  assign mem_gnt  = window && take_mem;
  assign if_gnt   = window && if_req && !take_mem;

  assign ram_en    = if_gnt || mem_gnt;
  assign ram_we    = mem_gnt && mem_we;
  assign ram_be    = mem_gnt ? mem_be   : (if_gnt ? BE_ALL  : 4'h0);
  assign ram_addr  = mem_gnt ? mem_addr : (if_gnt ? if_addr : '0);
  assign ram_wdata = mem_gnt ? mem_wdata : '0;

  assign if_rvalid  = !rst && resp && (owner_q == OWN_IF);
  assign mem_rvalid = !rst && resp && (owner_q == OWN_MEM);
  assign if_rdata   = if_rvalid  ? ram_rdata : '0;
  assign mem_rdata  = mem_rvalid ? ram_rdata : '0;

  assign stall_if  = !rst && ((if_req && !if_gnt) ||
                     ((state_q == ST_WAIT) && (owner_q == OWN_IF) && !if_rvalid));
  assign stall_mem = !rst && ((mem_req && !mem_gnt) ||
                     ((state_q == ST_WAIT) && (owner_q == OWN_MEM) && !mem_rvalid));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_cnt_d = lat_cnt_q;
    if (state_q == ST_WAIT) begin
      if (resp) begin
        state_d = ST_IDLE;
      end else begin
        lat_cnt_d = lat_cnt_q - 1'b1;
      end
    end
    if (ram_en && !ram_we) begin
      state_d   = ST_WAIT;
      lat_cnt_d = LAT_LOAD;
      owner_d   = mem_gnt ? OWN_MEM : OWN_IF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IF;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  pcpu_arb_fair #(
    .MAX_STREAK (MAX_STREAK)
  ) u_fair (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .mem_gnt  (mem_gnt),
    .if_gnt   (if_gnt),
    .force_if (force_if)
  );

`ifdef PCPU_ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic [15:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    starve_cnt_d   = starve_cnt_q;
    if (if_req && mem_req && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
    if (if_gnt && force_if && (starve_cnt_q != 16'hFFFF)) begin
      starve_cnt_d = starve_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_q <= '0;
      starve_cnt_q   <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      starve_cnt_q   <= starve_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign starve_cnt   = starve_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcpu_mem_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pcpu_mem_arb : directed self-checking bench, RD_LAT=2 and RD_LAT=1 DUTs
// Revision        : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_pcpu_mem_arb;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic          a_if_req, a_if_gnt, a_if_rvalid;
  logic [AW-1:0] a_if_addr;
  logic [31:0]   a_if_rdata;
  logic          a_mem_req, a_mem_we, a_mem_gnt, a_mem_rvalid;
  logic [3:0]    a_mem_be;
  logic [AW-1:0] a_mem_addr;
  logic [31:0]   a_mem_wdata, a_mem_rdata;
  logic          a_ram_en, a_ram_we, a_stall_if, a_stall_mem;
  logic [3:0]    a_ram_be;
  logic [AW-1:0] a_ram_addr;
  logic [31:0]   a_ram_wdata, a_ram_rdata;

  logic          b_if_req, b_if_gnt, b_if_rvalid;
  logic [AW-1:0] b_if_addr;
  logic [31:0]   b_if_rdata;
  logic          b_mem_req, b_mem_we, b_mem_gnt, b_mem_rvalid;
  logic [3:0]    b_mem_be;
  logic [AW-1:0] b_mem_addr;
  logic [31:0]   b_mem_wdata, b_mem_rdata;
  logic          b_ram_en, b_ram_we, b_stall_if, b_stall_mem;
  logic [3:0]    b_ram_be;
  logic [AW-1:0] b_ram_addr;
  logic [31:0]   b_ram_wdata, b_ram_rdata;

  // RAM models: word i holds 32'hA500_0000 | i after reset.
  logic [31:0] ram_a [0:1023];
  logic [31:0] ram_b [0:1023];
  logic [31:0] a_p1, a_p2, b_p1;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram_a[i] <= 32'hA500_0000 | 32'(i);
    end else if (a_ram_en && a_ram_we) begin
      for (int k = 0; k < 4; k++)
        if (a_ram_be[k]) ram_a[a_ram_addr][8*k +: 8] <= a_ram_wdata[8*k +: 8];
    end
    a_p1 <= (a_ram_en && !a_ram_we) ? ram_a[a_ram_addr] : 32'h0;
    a_p2 <= a_p1;
  end
  assign a_ram_rdata = a_p2;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram_b[i] <= 32'hA500_0000 | 32'(i);
    end else if (b_ram_en && b_ram_we) begin
      for (int k = 0; k < 4; k++)
        if (b_ram_be[k]) ram_b[b_ram_addr][8*k +: 8] <= b_ram_wdata[8*k +: 8];
    end
    b_p1 <= (b_ram_en && !b_ram_we) ? ram_b[b_ram_addr] : 32'h0;
  end
  assign b_ram_rdata = b_p1;

  pcpu_mem_arb #(.ADDR_W(AW), .RD_LAT(2), .MAX_STREAK(3)) u_dut_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_be(a_mem_be),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_gnt(a_mem_gnt),
    .mem_rvalid(a_mem_rvalid), .mem_rdata(a_mem_rdata),
    .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_be(a_ram_be),
    .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata),
    .stall_if(a_stall_if), .stall_mem(a_stall_mem)
  );

  pcpu_mem_arb #(.ADDR_W(AW), .RD_LAT(1), .MAX_STREAK(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_be(b_mem_be),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_gnt(b_mem_gnt),
    .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_be(b_ram_be),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
    .stall_if(b_stall_if), .stall_mem(b_stall_mem)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    a_if_req = 1'b1; a_if_addr = '0; a_mem_req = 1'b1; a_mem_we = 1'b0;
    a_mem_be = 4'h0; a_mem_addr = '0; a_mem_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_mem_req = 1'b0; b_mem_we = 1'b0;
    b_mem_be = 4'h0; b_mem_addr = '0; b_mem_wdata = '0;

    // Reset: outputs gated low even with requests pending
    repeat (3) @(posedge clk);
    #1; settle();
    chk("rst_if_gnt",    32'(a_if_gnt), 32'h0);
    chk("rst_mem_gnt",   32'(a_mem_gnt), 32'h0);
    chk("rst_ram_en",    32'(a_ram_en), 32'h0);
    chk("rst_stall_if",  32'(a_stall_if), 32'h0);
    chk("rst_stall_mem", 32'(a_stall_mem), 32'h0);

    // Lone IF read of 0x010
    cyc(); rst = 1'b0; a_mem_req = 1'b0; a_if_addr = 10'h010; settle();
    chk("t1_gnt",    32'(a_if_gnt), 32'h1);
    chk("t1_addr",   32'(a_ram_addr), 32'h010);
    chk("t1_be",     32'(a_ram_be), 32'hF);
    chk("t1_stall0", 32'(a_stall_if), 32'h0);
    cyc(); a_if_req = 1'b0; settle();
    chk("t1_stall1", 32'(a_stall_if), 32'h1);
    chk("t1_norv",   32'(a_if_rvalid), 32'h0);
    cyc(); settle();
    chk("t1_rv",     32'(a_if_rvalid), 32'h1);
    chk("t1_data",   a_if_rdata, 32'hA500_0010);
    chk("t1_stall2", 32'(a_stall_if), 32'h0);
    chk("t1_memrd",  a_mem_rdata, 32'h0);

    // MEM read 0x020 and IF read 0x030 collide
    cyc(); a_mem_req = 1'b1; a_mem_addr = 10'h020; a_if_req = 1'b1; a_if_addr = 10'h030; settle();
    chk("t2_mgnt",   32'(a_mem_gnt), 32'h1);
    chk("t2_ignt",   32'(a_if_gnt), 32'h0);
    chk("t2_addr",   32'(a_ram_addr), 32'h020);
    chk("t2_stl0",   32'(a_stall_if), 32'h1);
    cyc(); a_mem_req = 1'b0; settle();
    chk("t2_stm1",   32'(a_stall_mem), 32'h1);
    chk("t2_stl1",   32'(a_stall_if), 32'h1);
    cyc(); settle();
    chk("t2_mrv",    32'(a_mem_rvalid), 32'h1);
    chk("t2_mdata",  a_mem_rdata, 32'hA500_0020);
    chk("t2_ignt2",  32'(a_if_gnt), 32'h1);
    chk("t2_addr2",  32'(a_ram_addr), 32'h030);
    chk("t2_irdz",   a_if_rdata, 32'h0);
    cyc(); a_if_req = 1'b0; settle();
    chk("t2_stl3",   32'(a_stall_if), 32'h1);
    chk("t2_norv",   32'(a_if_rvalid), 32'h0);
    cyc(); settle();
    chk("t2_irv",    32'(a_if_rvalid), 32'h1);
    chk("t2_idata",  a_if_rdata, 32'hA500_0030);

    // Partial write then read-back of 0x040
    cyc(); a_mem_req = 1'b1; a_mem_we = 1'b1; a_mem_be = 4'b0011;
    a_mem_addr = 10'h040; a_mem_wdata = 32'hDEAD_BEEF; settle();
    chk("t3_gnt",    32'(a_mem_gnt), 32'h1);
    chk("t3_we",     32'(a_ram_we), 32'h1);
    chk("t3_be",     32'(a_ram_be), 32'h3);
    chk("t3_wdata",  a_ram_wdata, 32'hDEAD_BEEF);
    chk("t3_stm",    32'(a_stall_mem), 32'h0);
    cyc(); a_mem_we = 1'b0; a_mem_be = 4'h0; settle();
    chk("t3_norv",   32'(a_mem_rvalid), 32'h0);
    chk("t3_rgnt",   32'(a_mem_gnt), 32'h1);
    chk("t3_rwe",    32'(a_ram_we), 32'h0);
    cyc(); a_mem_req = 1'b0; settle();
    chk("t3_norv2",  32'(a_mem_rvalid), 32'h0);
    cyc(); settle();
    chk("t3_rv",     32'(a_mem_rvalid), 32'h1);
    chk("t3_data",   a_mem_rdata, 32'hA500_BEEF);

    // Streak: three MEM wins, then IF forced through
    cyc(); a_if_req = 1'b1; a_if_addr = 10'h050; a_mem_req = 1'b1; a_mem_addr = 10'h100; settle();
    chk("t4_g1",     32'(a_mem_gnt), 32'h1);
    cyc(); a_mem_addr = 10'h101; settle();
    chk("t4_wait",   32'(a_mem_gnt), 32'h0);
    cyc(); settle();
    chk("t4_g2",     32'(a_mem_gnt), 32'h1);
    cyc(); a_mem_addr = 10'h102; settle();
    cyc(); settle();
    chk("t4_g3",     32'(a_mem_gnt), 32'h1);
    chk("t4_g3if",   32'(a_if_gnt), 32'h0);
    cyc(); a_mem_addr = 10'h103; settle();
    cyc(); settle();
    chk("t4_force",  32'(a_if_gnt), 32'h1);
    chk("t4_fmgnt",  32'(a_mem_gnt), 32'h0);
    chk("t4_faddr",  32'(a_ram_addr), 32'h050);
    chk("t4_mrv",    a_mem_rdata, 32'hA500_0102);
    chk("t4_stm",    32'(a_stall_mem), 32'h1);
    cyc(); a_if_addr = 10'h051; settle();
    cyc(); settle();
    chk("t4_irv",    a_if_rdata, 32'hA500_0050);
    chk("t4_mgnt4",  32'(a_mem_gnt), 32'h1);
    chk("t4_ignt4",  32'(a_if_gnt), 32'h0);
    chk("t4_stl",    32'(a_stall_if), 32'h1);
    cyc(); a_mem_req = 1'b0; settle();
    cyc(); settle();
    chk("t4_mrv4",   a_mem_rdata, 32'hA500_0103);
    chk("t4_ignt5",  32'(a_if_gnt), 32'h1);
    chk("t4_addr5",  32'(a_ram_addr), 32'h051);
    cyc(); a_if_req = 1'b0; settle();
    cyc(); settle();
    chk("t4_irv5",   a_if_rdata, 32'hA500_0051);

    // Reset during an outstanding IF read
    cyc(); a_if_req = 1'b1; a_if_addr = 10'h060; settle();
    chk("t5_gnt",    32'(a_if_gnt), 32'h1);
    cyc(); a_if_addr = 10'h070; rst = 1'b1; settle();
    chk("t5_rgnt",   32'(a_if_gnt), 32'h0);
    chk("t5_rstl",   32'(a_stall_if), 32'h0);
    chk("t5_ren",    32'(a_ram_en), 32'h0);
    chk("t5_rrv",    32'(a_if_rvalid), 32'h0);
    cyc(); rst = 1'b0; settle();
    chk("t5_stale",  32'(a_if_rvalid), 32'h0);
    chk("t5_gnt2",   32'(a_if_gnt), 32'h1);
    chk("t5_addr2",  32'(a_ram_addr), 32'h070);
    cyc(); a_if_req = 1'b0; settle();
    chk("t5_norv",   32'(a_if_rvalid), 32'h0);
    cyc(); settle();
    chk("t5_rv",     32'(a_if_rvalid), 32'h1);
    chk("t5_data",   a_if_rdata, 32'hA500_0070);

    // RD_LAT=1 back-to-back IF reads 0x000..0x003
    cyc(); b_if_req = 1'b1; b_if_addr = 10'h000; settle();
    chk("t6_g0",     32'(b_if_gnt), 32'h1);
    chk("t6_rv0",    32'(b_if_rvalid), 32'h0);
    chk("t6_s0",     32'(b_stall_if), 32'h0);
    cyc(); b_if_addr = 10'h001; settle();
    chk("t6_g1",     32'(b_if_gnt), 32'h1);
    chk("t6_d1",     b_if_rdata, 32'hA500_0000);
    chk("t6_s1",     32'(b_stall_if), 32'h0);
    cyc(); b_if_addr = 10'h002; settle();
    chk("t6_g2",     32'(b_if_gnt), 32'h1);
    chk("t6_d2",     b_if_rdata, 32'hA500_0001);
    cyc(); b_if_addr = 10'h003; settle();
    chk("t6_g3",     32'(b_if_gnt), 32'h1);
    chk("t6_d3",     b_if_rdata, 32'hA500_0002);
    chk("t6_s3",     32'(b_stall_if), 32'h0);
    cyc(); b_if_req = 1'b0; settle();
    chk("t6_rv4",    32'(b_if_rvalid), 32'h1);
    chk("t6_d4",     b_if_rdata, 32'hA500_0003);
    chk("t6_s4",     32'(b_stall_if), 32'h0);
    cyc(); settle();
    chk("t6_idle",   32'(b_if_rvalid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pcpu_mem_arb.md
Name: pcpu_mem_arb

Overview:
- Arbitrates one single-port unified RAM between the instruction-fetch port (IF, read-only) and the data-memory port (MEM, read/write) of the pipelined CPU.
- Issues at most one RAM access at a time and tracks the outstanding read latency.
- Routes read data back to whichever requester owns the access.
- Drives per-stage stall signals that feed the pipeline control's IF/ID and ID/EX hold logic.

Parameters:
- ADDR_W, 10, word-address width of the RAM.
- RD_LAT, 2, RAM read latency in cycles. Legal range 1..8.
- MAX_STREAK, 3, consecutive MEM grants allowed while IF waits before IF is forced through.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  IF read request.
- if_addr  in  ADDR_W  IF word address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  IF read data valid.
- if_rdata  out  32  IF read data.
- mem_req  in  1  MEM request.
- mem_we  in  1  MEM request is a write.
- mem_be  in  4  MEM byte enables (used on writes).
- mem_addr  in  ADDR_W  MEM word address.
- mem_wdata  in  32  MEM write data.
- mem_gnt  out  1  MEM request accepted this cycle.
- mem_rvalid  out  1  MEM read data valid.
- mem_rdata  out  32  MEM read data.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write strobe.
- ram_be  out  4  RAM byte enables.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid RD_LAT cycles after ram_en.
- stall_if  out  1  hold the IF stage.
- stall_mem  out  1  hold the MEM stage.

Behaviour:
- Clocking and reset: single clock domain, clk. rst is asynchronous and active-high.
- While rst is high:
  - State returns to IDLE.
  - Latency counter, streak counter and owner flag clear.
  - All outputs are 0, including combinational ones, which are gated by rst.
- States:
  - IDLE: no access outstanding.
  - WAIT: a read is outstanding; lat_cnt counts down from RD_LAT-1.
- Arbitration window:
  - Open in IDLE.
  - Open in the WAIT cycle where lat_cnt==0, which is the response cycle. This allows back-to-back reads: one read per RD_LAT cycles; with RD_LAT=1, one read per cycle.
- Grant is combinational, in the same cycle as the request: gnt=1 and ram_en=1, with ram_addr/ram_we/ram_be/ram_wdata muxed from the winner.
- Priority:
  - MEM wins over IF.
  - Exception: if if_req=1 and streak==MAX_STREAK, IF wins.
- Streak counter:
  - Increments on each MEM grant while if_req=1, saturating at MAX_STREAK.
  - Clears on an IF grant, or on any cycle with if_req=0.
- Writes (mem_we=1):
  - Complete in the grant cycle; no rvalid.
  - State goes to (or stays) IDLE, unless a read is also concurrently completing — impossible by construction.
- Reads:
  - On grant, the owner flag latches the winner and the state enters WAIT.
  - Exactly RD_LAT cycles after grant, the owner's rvalid=1 and rdata=ram_rdata (passthrough).
  - The non-owner's rdata is 0.
- Response plus new grant in the same cycle is legal. If the new grant is a write, state goes to IDLE after the response; if it is a read, WAIT reloads.
- Requester rules:
  - req and its address/data are held stable until gnt.
  - req may drop or change in the cycle after gnt.
  - A requester has at most one outstanding read.
- Stalls: stall_X = (X_req & ~X_gnt) | (X read outstanding & ~X_rvalid).
- Reset mid-read: the outstanding read is discarded and no rvalid is ever produced for it.
- Address and byte-enable width rules: addresses pass unmodified; IF accesses drive ram_be=4'hF and ram_we=0.

Optional Feature:
- Macro PCPU_ARB_STATS_EN.
- When defined, adds output ports:
  - conflict_cnt[15:0]: cycles with if_req & mem_req both high.
  - starve_cnt[15:0]: forced IF grants.
- Both counters are saturating and cleared by rst.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pcpu_arb_pkg:
  - state encoding (IDLE, WAIT).
  - owner encoding (OWN_IF=0, OWN_MEM=1).
  - RAM data width constant (32).
  - byte-enable-all constant 4'hF.
- One natural sub-module, pcpu_arb_fair:
  - contains the streak counter and the forced-IF decision.
  - inputs: clk, rst, if_req, mem_gnt, if_gnt.
  - output: force_if.

Test Plan:
- RD_LAT=2, IF read 0x010 alone → if_gnt at t0, if_rvalid at t2 with RAM word 0x010, stall_if high t0+1..t1, low at t2.
- Both request at t0 (MEM read 0x020, IF read 0x030) → mem_gnt t0, mem_rvalid t2; if_gnt t2, if_rvalid t4; stall_if high t0..t3.
- MEM write 0x040 = 0xDEADBEEF, be=4'b0011 → mem_gnt t0, ram_we=1, no rvalid; a later read returns only low half updated.
- MEM requests every window with IF pending, MAX_STREAK=3 → 3 MEM grants, then the 4th window grants IF; streak resets.
- rst asserted at t1 of an outstanding IF read → outputs 0 immediately, no if_rvalid at t2; after release, a new IF read works normally.
- RD_LAT=1, IF reads back-to-back 0x000..0x003 → one grant and one rvalid per cycle, stall_if low after the first cycle.
